// File: rtl/prio_enc_pkg.sv
// Shared types and constants for the switch debounce / 8-to-3 priority encoder.
// The encode helper returns the index of the highest set bit (0 when none set).
package prio_enc_pkg;

  localparam int DEB_CYCLES_DEF = 16;
  localparam int SW_W           = 8;
  localparam int CODE_W         = 3;

  typedef logic [CODE_W-1:0] code_t;

  function automatic code_t prio_encode(input logic [SW_W-1:0] bits);
    code_t c;
    c = '0;
    for (int i = 0; i < SW_W; i++) begin
      if (bits[i]) c = code_t'(i);
    end
    return c;
  endfunction

endpackage

// File: rtl/prio_enc83_debounce_if.sv
// Switch-side inputs and decoder-side outputs of prio_enc83_debounce.
// chg_cnt exists only when PRIO_ENC_CHG_CNT_EN is defined.
interface prio_enc83_debounce_if;
  import prio_enc_pkg::*;

  logic [SW_W-1:0] sw;
  logic            en_in;
  code_t           code;
  logic            valid;
  logic            en_out;
  logic            changed;
`ifdef PRIO_ENC_CHG_CNT_EN
  logic [7:0]      chg_cnt;

  modport master (output sw, en_in, input code, valid, en_out, changed, chg_cnt);
  modport slave  (input sw, en_in, output code, valid, en_out, changed, chg_cnt);
`else
  modport master (output sw, en_in, input code, valid, en_out, changed);
  modport slave  (input sw, en_in, output code, valid, en_out, changed);
`endif

endinterface

// File: rtl/prio_enc83_debounce_sync_debounce.sv
// Two-flop synchroniser plus per-vector debounce; stab follows raw after DEB_CYCLES+1 equal samples.
// Latency: raw change to stab is DEB_CYCLES+2 edges; no backpressure.
module sync_debounce #(
  parameter int W          = 9,
  parameter int DEB_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] raw,
  output logic [W-1:0] stab
);

  localparam int            CW      = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [W-1:0]  meta;
  logic [W-1:0]  s;
  logic [W-1:0]  cand;
  logic [CW-1:0] cnt;

  // Counter saturates at CNT_MAX; stab is re-loaded every cycle while input stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      s    <= '0;
      cand <= '0;
      cnt  <= '0;
      stab <= '0;
    end else begin
      meta <= raw;
      s    <= meta;
      if (s != cand) begin
        cand <= s;
        cnt  <= '0;
      end else if (cnt == CNT_MAX) begin
        stab <= cand;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_enc83_debounce.sv
// Debounced 8-to-3 priority encoder feeding a 7-segment decoder; optional chg_cnt via PRIO_ENC_CHG_CNT_EN.
// Latency: DEB_CYCLES+3 edges from first raw capture to code/valid; no backpressure.
module prio_enc83_debounce
  import prio_enc_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input logic                    clk,
  input logic                    rst_n,
  prio_enc83_debounce_if.slave   bus
);

  logic [SW_W:0] stab;
  code_t         code_d;
  logic          valid_d;
  code_t         code_q;
  logic          valid_q;
  logic          en_out_q;
  code_t         code_prev;
  logic          valid_prev;
  logic          changed_q;

  sync_debounce #(
    .W          (SW_W + 1),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_sync_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   ({bus.en_in, bus.sw}),
    .stab  (stab)
  );

  always_comb begin
    valid_d = stab[SW_W] && (stab[SW_W-1:0] != '0);
    code_d  = valid_d ? prio_encode(stab[SW_W-1:0]) : '0;
  end

  // changed compares the output register against its own previous value, so it lags code by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q     <= '0;
      valid_q    <= 1'b0;
      en_out_q   <= 1'b0;
      code_prev  <= '0;
      valid_prev <= 1'b0;
      changed_q  <= 1'b0;
    end else begin
      code_q     <= code_d;
      valid_q    <= valid_d;
      en_out_q   <= valid_d;
      code_prev  <= code_q;
      valid_prev <= valid_q;
      changed_q  <= {code_q, valid_q} != {code_prev, valid_prev};
    end
  end

  assign bus.code    = code_q;
  assign bus.valid   = valid_q;
  assign bus.en_out  = en_out_q;
  assign bus.changed = changed_q;

`ifdef PRIO_ENC_CHG_CNT_EN
  logic [7:0] chg_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg_cnt_q <= '0;
    end else if (changed_q) begin
      chg_cnt_q <= chg_cnt_q + 8'd1;
    end
  end

  assign bus.chg_cnt = chg_cnt_q;
`endif

endmodule
